pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter N, default 3, meaning the width of the upstream counter's count value (period = 2^N cycles).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port count  input  N  free-running count from the upstream counter, advancing by one per clk and wrapping from 2^N-1 to 0.
REQ-005 SHALL have port en  input  1  level request to run PWM output.
REQ-006 SHALL have port duty  input  N+1  requested high time per period, in cycles, valid range 0..2^N.
REQ-007 SHALL have port duty_valid  input  1  duty presented this cycle.
REQ-008 SHALL have port duty_ready  output  1  block can accept a duty value this cycle.
REQ-009 SHALL have port pwm  output  1  registered PWM waveform.
REQ-010 SHALL have port period_start  output  1  registered one-cycle pulse marking the first cycle of each driven period.

Function
REQ-011 SHALL define boundary as: count == 0 and the previous cycle's sampled count == 2^N-1 (prev register).
REQ-012 SHALL implement states OFF, ARMED, RUN, DRAIN.
REQ-013 SHALL transition: OFF->ARMED on en=1; ARMED->RUN on boundary with en=1; ARMED->OFF on en=0; RUN->DRAIN on en=0 (non-boundary cycle); RUN->OFF on en=0 in a boundary cycle; DRAIN->OFF on boundary; DRAIN->RUN on en=1 (non-boundary cycle); otherwise hold.
REQ-014 SHALL accept a duty value on a cycle where duty_valid=1 and duty_ready=1; duty_ready = NOT pending.
REQ-015 SHALL store an accepted value in a shadow register and set pending; values above 2^N clip to 2^N.
REQ-016 SHALL copy the shadow register into the active duty and clear pending on a boundary cycle, in every state.
REQ-017 SHALL treat a value accepted in a boundary cycle as pending for the next boundary, not the current one.
REQ-018 SHALL compute duty_nxt = shadow if (boundary and pending) else active duty.
REQ-019 SHALL register pwm <= (next state is RUN or DRAIN) and (count < duty_nxt): one-cycle latency from count.
REQ-020 SHALL give duty=0 -> pwm constantly 0; duty=2^N -> pwm constantly 1 while driven.
REQ-021 SHALL register period_start <= boundary and (next state is RUN or DRAIN); it is never high in OFF or ARMED.
REQ-022 SHALL never change active duty mid-period (glitch-free update).

Reset
REQ-023 SHALL, while reset=1, force state OFF, pwm 0, period_start 0, pending 0, active duty 0, shadow 0, prev register all ones; duty_ready 1.
REQ-024 SHALL, on reset asserted mid-period, drop pwm to 0 on the next clk edge and discard any pending duty.
REQ-025 SHALL, with the prev register reset to all ones, treat the first count==0 after reset as a boundary.

Structure
REQ-026 SHALL place the state enum (OFF, ARMED, RUN, DRAIN) in a shared package pwm_pkg.
REQ-027 SHALL use one sub-module, wrap_detect, holding the prev register and producing boundary.
REQ-028 SHALL instantiate alongside the existing counter, with count connected directly and the same clk/reset.

Verification (N=3, period 8)
REQ-029 SHALL cover: duty=3 accepted, en=1 -> pwm high 3 cycles, low 5, repeating; period_start one cycle per 8, coincident with the first pwm high cycle.
REQ-030 SHALL cover: duty=0, then duty=8 -> pwm all low, then all high from the following boundary; duty=12 -> behaves as 8.
REQ-031 SHALL cover: duty=2 running, duty=6 accepted mid-period -> current period keeps 2 high; next period 6 high; duty_ready low until that boundary.
REQ-032 SHALL cover: en dropped at count=4 with duty=6 -> pwm completes the period (high through the count=5 cycle), state OFF after boundary, no further period_start.
REQ-033 SHALL cover: en=1 at count=3 -> state ARMED, pwm low until the next count==0, then RUN.
REQ-034 SHALL cover: reset pulse at count=2 during RUN -> pwm 0 and duty_ready 1 on the next edge; after release, the first count==0 is a boundary.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and next-state rule for the PWM generator
package pwm_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } pwm_state_e;

  // DRAIN lets the current period finish once en drops; it stops only at the wrap.
  function automatic pwm_state_e pwm_next_state(input pwm_state_e cur,
                                                input logic en,
                                                input logic boundary);
    pwm_state_e nxt;
    nxt = cur;
    case (cur)
      OFF:   if (en) nxt = ARMED;
      ARMED: if (!en) nxt = OFF;
             else if (boundary) nxt = RUN;
      RUN:   if (!en) nxt = boundary ? OFF : DRAIN;
      DRAIN: if (boundary) nxt = OFF;
             else if (en) nxt = RUN;
      default: nxt = OFF;
    endcase
    return nxt;
  endfunction

  function automatic logic pwm_is_driving(input pwm_state_e s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/pwm_gen_wrap_detect.sv
// rtl/pwm_gen_wrap_detect.sv - flags the cycle where the upstream count wraps to zero
module wrap_detect #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] count_i,
  output logic         boundary_o
);

  logic [N-1:0] prev_q;

  // Reset to all ones so the first count==0 after reset counts as a wrap.
  always_ff @(posedge clk_i) begin
    if (reset_i) prev_q <= '1;
    else         prev_q <= count_i;
  end

  assign boundary_o = (count_i == '0) && (prev_q == '1);

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - period-aligned PWM generator with a shadowed, glitch-free duty update
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] count,
  input  logic         en,
  input  logic [N:0]   duty,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm,
  output logic         period_start
);

  localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};

  pwm_state_e state_q, state_d;
  logic [N:0] shadow_q, shadow_d;
  logic [N:0] active_q, active_d;
  logic       pending_q, pending_d;
  logic       pwm_q, period_start_q;
  logic       boundary;
  logic       accept;
  logic       drive_d;
  logic [N:0] duty_clip;
  logic [N:0] duty_nxt;

  wrap_detect #(.N(N)) u_wrap_detect (
    .clk_i      (clk),
    .reset_i    (reset),
    .count_i    (count),
    .boundary_o (boundary)
  );

  assign duty_ready = ~pending_q;
  assign accept     = duty_valid && ~pending_q;
  assign duty_clip  = (duty > DUTY_MAX) ? DUTY_MAX : duty;
  assign duty_nxt   = (boundary && pending_q) ? shadow_q : active_q;

  // A value accepted on a wrap cycle sets pending after the copy, so it waits a full period.
  always_comb begin
    state_d   = pwm_next_state(state_q, en, boundary);
    drive_d   = pwm_is_driving(state_d);
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary) begin
      active_d  = duty_nxt;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = duty_clip;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= OFF;
      shadow_q       <= '0;
      active_q       <= '0;
      pending_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pwm_q          <= drive_d && ({1'b0, count} < duty_nxt);
      period_start_q <= drive_d && boundary;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed scoreboard bench for pwm_gen at N=3 (period 8)
module tb_pwm_gen;
  import pwm_pkg::*;

  localparam int N = 3;

  typedef struct packed {
    logic pwm;
    logic ps;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] count;
  logic         en;
  logic [N:0]   duty;
  logic         duty_valid;
  logic         duty_ready;
  logic         pwm;
  logic         period_start;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pwm_gen #(.N(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .count        (count),
    .en           (en),
    .duty         (duty),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm          (pwm),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pwm/period_start for the current count is queued before the edge and checked after it.
  task automatic run_cycles(input int d, input int n, input bit drv, input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pwm = drv && (int'(count) < d);
      e.ps  = drv && (count == '0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check1({tag, ".pwm"}, {3'b0, pwm}, {3'b0, e.pwm});
      check1({tag, ".period_start"}, {3'b0, period_start}, {3'b0, e.ps});
      duty_valid = 1'b0;
      count = reset ? '0 : count + 3'd1;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; duty = '0; duty_valid = 1'b0; count = '0;
    run_cycles(0, 2, 0, "reset");
    check1("reset.ready", {3'b0, duty_ready}, 4'd1);
    check1("reset.state", 4'(dut.state_q), 4'(OFF));
    check1("reset.active", dut.active_q, 4'd0);

    reset = 1'b0;
    #1;
    check1("first_zero_boundary", {3'b0, dut.boundary}, 4'd1);

    // duty=3, en=1: armed for one period, then 3 high / 5 low
    en = 1'b1; duty = 4'd3; duty_valid = 1'b1;
    run_cycles(0, 1, 0, "armA");
    check1("armA.ready", {3'b0, duty_ready}, 4'd0);
    check1("armA.state", 4'(dut.state_q), 4'(ARMED));
    run_cycles(0, 7, 0, "armA");
    run_cycles(3, 16, 1, "d3");
    check1("d3.ready", {3'b0, duty_ready}, 4'd1);

    // duty 0, then 8, then 12 (clipped to 8)
    duty = 4'd0; duty_valid = 1'b1;
    run_cycles(3, 8, 1, "d3b");
    run_cycles(0, 8, 1, "d0");
    duty = 4'd8; duty_valid = 1'b1;
    run_cycles(0, 8, 1, "d0b");
    run_cycles(8, 8, 1, "d8");
    duty = 4'd12; duty_valid = 1'b1;
    run_cycles(8, 8, 1, "d8b");
    run_cycles(8, 1, 1, "d12");
    check1("d12.clip", dut.active_q, 4'd8);
    run_cycles(8, 7, 1, "d12");

    // duty 2 running, 6 accepted mid-period
    duty = 4'd2; duty_valid = 1'b1;
    run_cycles(8, 8, 1, "d8c");
    run_cycles(2, 3, 1, "d2");
    duty = 4'd6; duty_valid = 1'b1;
    run_cycles(2, 1, 1, "d2mid");
    check1("d2mid.ready", {3'b0, duty_ready}, 4'd0);
    run_cycles(2, 4, 1, "d2mid");
    check1("d2end.ready", {3'b0, duty_ready}, 4'd0);
    run_cycles(6, 1, 1, "d6");
    check1("d6.ready", {3'b0, duty_ready}, 4'd1);
    run_cycles(6, 7, 1, "d6");

    // en dropped at count=4: period completes, then OFF
    run_cycles(6, 4, 1, "drain");
    en = 1'b0;
    run_cycles(6, 1, 1, "drain");
    check1("drain.state", 4'(dut.state_q), 4'(DRAIN));
    run_cycles(6, 3, 1, "drain");
    run_cycles(6, 9, 0, "off");
    check1("off.state", 4'(dut.state_q), 4'(OFF));

    // en raised at count=3: armed until the next wrap
    run_cycles(6, 2, 0, "idle");
    en = 1'b1;
    run_cycles(6, 1, 0, "armE");
    check1("armE.state", 4'(dut.state_q), 4'(ARMED));
    run_cycles(6, 4, 0, "armE");
    run_cycles(6, 8, 1, "runE");

    // reset pulse at count=2 with a pending duty
    run_cycles(6, 1, 1, "preRst");
    duty = 4'd1; duty_valid = 1'b1;
    run_cycles(6, 1, 1, "preRst");
    check1("preRst.ready", {3'b0, duty_ready}, 4'd0);
    reset = 1'b1;
    run_cycles(6, 1, 0, "rstMid");
    check1("rstMid.ready", {3'b0, duty_ready}, 4'd1);
    check1("rstMid.state", 4'(dut.state_q), 4'(OFF));
    reset = 1'b0;
    #1;
    check1("rstMid.boundary", {3'b0, dut.boundary}, 4'd1);
    run_cycles(0, 1, 0, "postRst");
    check1("postRst.state", 4'(dut.state_q), 4'(ARMED));
    check1("postRst.active", dut.active_q, 4'd0);
    check1("postRst.noboundary", {3'b0, dut.boundary}, 4'd0);
    duty = 4'd5; duty_valid = 1'b1;
    run_cycles(0, 7, 0, "postRst");
    run_cycles(5, 8, 1, "d5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
